// File: rtl/mul_seq_ctrl_if.sv
// ============================================================================
// Module   : mul_seq_ctrl_if
// Brief    : Issue/writeback handshake bundle for the shift-add multiply sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_seq_ctrl_if #(
   parameter int N = 32
);
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] product;
   logic           busy;

   // master = issuer/writeback side, slave = the sequencer
   modport master (
      output flush, in_valid, op_a, op_b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  flush, in_valid, op_a, op_b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module   : mul_seq_ctrl
// Brief    : Unsigned NxN->2N shift-add multiply sequencer driving an external adder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_ctrl #(
   parameter int N  = 32,
   parameter int CW = 6
) (
   input  wire logic         clk,
   input  wire logic         rst,
   mul_seq_ctrl_if.slave     bus,
   output logic [N-1:0]      add_a,
   output logic [N-1:0]      add_b,
   output logic              add_cin,
   input  wire logic [N-1:0] add_sum,
   input  wire logic         add_cout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] C_LAST = CW'(N - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   logic [1:0]    r_state;
   logic [N-1:0]  r_m;
   logic [N-1:0]  r_p_hi;
   logic [N-1:0]  r_p_lo;
   logic [CW-1:0] r_cnt;

   logic          w_run;

   assign w_run = (r_state == S_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_p_hi  <= '0;
         r_p_lo  <= '0;
         r_cnt   <= '0;
      end else if (bus.flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_m     <= bus.op_a;
                  r_p_lo  <= bus.op_b;
                  r_p_hi  <= '0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // 2N+1-bit right shift of {cout, sum, P_lo}; the adder carry lands in P_hi[N-1]
               r_p_hi <= {add_cout, add_sum[N-1:1]};
               r_p_lo <= {add_sum[0], r_p_lo[N-1:1]};
               r_cnt  <= r_cnt + C_ONE;
               if (r_cnt == C_LAST) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Adder operands are forced to zero outside RUN so the adder stays quiet
   assign add_a   = w_run ? r_p_hi : '0;
   assign add_b   = (w_run && r_p_lo[0]) ? r_m : '0;
   assign add_cin = 1'b0;

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.product   = {r_p_hi, r_p_lo};

endmodule

`default_nettype wire
